// File: rtl/neighbor_picker.sv
`default_nettype none
// ============================================================================
// Module      : neighbor_picker
// Description : Picks one set bit of an availability mask, scanning upward
//               from an LFSR-chosen start; reports "none" for an empty mask.
//               Optional LFSR reseed port: NEIGHBOR_PICK_SEED_LOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module neighbor_picker #(
    parameter int                    SELECT_WIDTH = 2,
    parameter int                    LFSR_WIDTH   = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS    = 16'hB400,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset_n,
`ifdef NEIGHBOR_PICK_SEED_LOAD_EN
    input  logic                         seed_load,
    input  logic [LFSR_WIDTH-1:0]        seed,
`endif
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [(2**SELECT_WIDTH)-1:0] avail_mask,
    output logic                         pick_valid,
    input  logic                         pick_ready,
    output logic [SELECT_WIDTH-1:0]      pick_index,
    output logic                         pick_none
);

    localparam int                    c_num_cand = 2 ** SELECT_WIDTH;
    localparam logic [LFSR_WIDTH-1:0] c_one      = {{(LFSR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LFSR_WIDTH-1:0] c_seed     = (LFSR_SEED == '0) ? c_one : LFSR_SEED;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [LFSR_WIDTH-1:0]    lfsr_q, lfsr_d;
    logic [c_num_cand-1:0]    mask_q, mask_d;
    logic [SELECT_WIDTH-1:0]  cur_q, cur_d;
    logic                     pick_valid_q, pick_valid_d;
    logic [SELECT_WIDTH-1:0]  pick_index_q, pick_index_d;
    logic                     pick_none_q, pick_none_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[LFSR_WIDTH-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
`ifdef NEIGHBOR_PICK_SEED_LOAD_EN
        if (seed_load) begin
            lfsr_d = (seed == '0) ? c_one : seed;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        cur_d        = cur_q;
        pick_valid_d = pick_valid_q;
        pick_index_d = pick_index_q;
        pick_none_d  = pick_none_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    mask_d       = avail_mask;
                    cur_d        = lfsr_q[SELECT_WIDTH-1:0];
                    pick_index_d = '0;
                    pick_none_d  = (avail_mask == '0);
                    if (avail_mask == '0) begin
                        pick_valid_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        state_d      = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                // Mask is known nonzero here, so the wrap-around walk always terminates.
                if (mask_q[cur_q]) begin
                    pick_index_d = cur_q;
                    pick_none_d  = 1'b0;
                    pick_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    cur_d        = cur_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (pick_ready) begin
                    pick_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= c_seed;
            mask_q       <= '0;
            cur_q        <= '0;
            pick_valid_q <= 1'b0;
            pick_index_q <= '0;
            pick_none_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            mask_q       <= mask_d;
            cur_q        <= cur_d;
            pick_valid_q <= pick_valid_d;
            pick_index_q <= pick_index_d;
            pick_none_q  <= pick_none_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign pick_valid = pick_valid_q;
    assign pick_index = pick_index_q;
    assign pick_none  = pick_none_q;

endmodule
`default_nettype wire
